// File: rtl/rv_pkg.sv
// Shared definitions for the RV32M iterative divider: operand width,
// divide op encoding (funct3[1:0]) and the divider FSM state type.
package rv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring-division iteration: shift {rem, quo} left by one,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quo,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic [W-1:0] quo_next
);

   // One extra bit so the borrow of the trial subtraction is visible.
   logic [W:0] shifted;
   logic [W:0] diff;

   always_comb begin
      shifted  = {rem, quo[W-1]};
      diff     = shifted - {1'b0, divisor};
      quo_next = {quo[W-2:0], ~diff[W]};
      rem_next = diff[W] ? shifted[W-1:0] : diff[W-1:0];
   end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) answering the EX-stage divide
// request; special cases finish in one cycle, others take XLEN iterations.
module div_iter
   import rv_pkg::*;
#(
   parameter int XLEN = rv_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   div_state_t      state;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] dvsr_q;
   logic            sel_rem;
   logic            neg_q;
   logic            neg_r;

   div_op_t         op_e;
   logic            is_signed_op;
   logic            a_neg;
   logic            b_neg;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] spec_res;
   logic [XLEN-1:0] rem_nx;
   logic [XLEN-1:0] quo_nx;
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;

   div_step #(.W(XLEN)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvsr_q),
      .rem_next (rem_nx),
      .quo_next (quo_nx)
   );

   // NOTE: every signal is assigned on every path through always_comb; a
   // missing assignment on some branch would infer a latch.
   always_comb begin
      op_e         = div_op_t'(op);
      is_signed_op = (op_e == DIV) || (op_e == REM);
      a_neg        = is_signed_op && src1[XLEN-1];
      b_neg        = is_signed_op && src2[XLEN-1];
      a_mag        = a_neg ? -src1 : src1;
      b_mag        = b_neg ? -src2 : src2;
      div_zero     = (src2 == '0);
      ovf          = is_signed_op && (src1 == MIN_NEG) && (src2 == '1);
      // Divide-by-zero and signed overflow are answered directly at accept.
      if (op[1])
         spec_res = div_zero ? src1 : '0;
      else
         spec_res = div_zero ? '1 : MIN_NEG;
      q_fix = neg_q ? -quo_nx : quo_nx;
      r_fix = neg_r ? -rem_nx : rem_nx;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvsr_q     <= '0;
         sel_rem    <= 1'b0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         result     <= '0;
         busy       <= 1'b0;
      end else if (flush) begin
         state      <= IDLE;
         count      <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         result     <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  sel_rem   <= op[1];
                  neg_q     <= a_neg ^ b_neg;
                  neg_r     <= a_neg;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (div_zero || ovf) begin
                     state      <= DONE;
                     resp_valid <= 1'b1;
                     result     <= spec_res;
                  end else begin
                     state  <= CALC;
                     count  <= CW'(XLEN - 1);
                     rem_q  <= '0;
                     quo_q  <= a_mag;
                     dvsr_q <= b_mag;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               count <= count - CW'(1);
               if (count == '0) begin
                  state      <= DONE;
                  resp_valid <= 1'b1;
                  result     <= sel_rem ? r_fix : q_fix;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
                  result     <= '0;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               result     <= '0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
